button_debounce_pulse: RTL

- Conditions one raw, asynchronous, bouncing push-button input into a clean level and single-cycle edge pulses.
- press_pulse drives the increment input of the modulo counter stage directly downstream.
- Sits between board I/O pins and the counter/FSM logic in the lab-style top levels.
- Contains a two-flop synchronizer, a stability timer and a 4-state debounce FSM.

---
 rtl/button_debounce_pkg.sv | 11 +
 rtl/button_debounce_pulse_sync_2ff.sv | 27 ++
 rtl/button_debounce_pulse.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared state encoding for the push-button debouncer
package button_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } deb_state_e;

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// rtl/button_debounce_pulse_sync_2ff.sv - generic two-flop synchronizer with configurable reset value
module sync_2ff #(
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= RESET_VALUE;
            stage2_q <= RESET_VALUE;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// rtl/button_debounce_pulse.sv - debounced level plus press/release pulses from a raw button
// Optional hold-to-repeat press pulses when BUTTON_DEBOUNCE_AUTO_REPEAT_EN is defined.
module button_debounce_pulse
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMER_WIDTH     = 19,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_WIDTH    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_clean,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(DEBOUNCE_CYCLES - 1);

    deb_state_e             state_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic                   btn_clean_q;
    logic                   press_q;
    logic                   release_q;
    logic                   btn_sync;
    logic                   rpt_fire;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (btn_sync)
    );

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [REPEAT_WIDTH-1:0] HOLD_LAST   = REPEAT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [REPEAT_WIDTH-1:0] REPEAT_LAST = REPEAT_WIDTH'(REPEAT_CYCLES - 1);

    logic [REPEAT_WIDTH-1:0] rpt_q;
    logic [REPEAT_WIDTH-1:0] rpt_d;
    logic                    rpt_armed_q;
    logic                    rpt_armed_d;

    // First fire waits the long hold time, later fires use the shorter repeat period.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire    = 1'b0;
        if (state_q == S_HIGH && btn_sync) begin
            if (rpt_q == (rpt_armed_q ? REPEAT_LAST : HOLD_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_d       = '0;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end else begin
            rpt_d       = '0;
            rpt_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOW;
            timer_q     <= '0;
            btn_clean_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                S_LOW: begin
                    btn_clean_q <= 1'b0;
                    timer_q     <= '0;
                    if (btn_sync) begin
                        state_q <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!btn_sync) begin
                        state_q <= S_LOW;
                        timer_q <= '0;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q     <= S_HIGH;
                        timer_q     <= '0;
                        btn_clean_q <= 1'b1;
                        press_q     <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_HIGH: begin
                    btn_clean_q <= 1'b1;
                    timer_q     <= '0;
                    if (!btn_sync) begin
                        state_q <= S_WAIT_LOW;
                    end else begin
                        press_q <= rpt_fire;
                    end
                end
                S_WAIT_LOW: begin
                    if (btn_sync) begin
                        state_q <= S_HIGH;
                        timer_q <= '0;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q     <= S_LOW;
                        timer_q     <= '0;
                        btn_clean_q <= 1'b0;
                        release_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_LOW;
                    timer_q     <= '0;
                    btn_clean_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_clean     = btn_clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule
